pixel_config: RTL and testbench

- Downstream consumer of the SPI slave interface's register-001 configuration stream.
- Each `config_en` pulse accepts the 6-bit double-column pixel configuration word, taken from SPI `data_out[5:0]`, and shifts it into a chain covering the whole matrix.
- The chain's tail bit returns to the SPI interface as `config_do`, so the host can read the configuration back.
- A `push_clk` request latches the chain into a shadow register that drives the pixel matrix, then issues a timed write strobe.

---
 rtl/pixel_config_if.sv | 30 +++
 rtl/pixel_config.sv | 124 ++++++++++++
 tb/tb_pixel_config.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_config_if.sv
// Configuration-stream bus between the SPI slave interface (master side)
// and the pixel-matrix configuration block (slave side).
interface pixel_config_if #(
    parameter int unsigned NUM_DCOL = 8
);
    localparam int unsigned CHAIN_W = NUM_DCOL * 6;
    localparam int unsigned CNT_W   = $clog2(NUM_DCOL + 1);

    logic               config_en;
    logic [5:0]         config_data;
    logic               push_clk;
    logic               err_clr;
    logic               config_do;
    logic [CHAIN_W-1:0] pix_cfg;
    logic               pix_wr;
    logic               cfg_busy;
    logic               cfg_full;
    logic [CNT_W-1:0]   word_cnt;
    logic               cfg_err;

    modport master (
        output config_en, config_data, push_clk, err_clr,
        input  config_do, pix_cfg, pix_wr, cfg_busy, cfg_full, word_cnt, cfg_err
    );

    modport slave (
        input  config_en, config_data, push_clk, err_clr,
        output config_do, pix_cfg, pix_wr, cfg_busy, cfg_full, word_cnt, cfg_err
    );
endinterface

// File: rtl/pixel_config.sv
// Pixel double-column configuration chain with shadow register and a timed
// matrix write strobe triggered by the SPI push request.
module pixel_config #(
    parameter int unsigned NUM_DCOL  = 8,
    parameter int unsigned PULSE_LEN = 4
) (
    input  logic           spi_clk,
    input  logic           rst,
    pixel_config_if.slave  bus
);
    localparam int unsigned CHAIN_W = NUM_DCOL * 6;
    localparam int unsigned CNT_W   = $clog2(NUM_DCOL + 1);
    localparam int unsigned PCNT_W  = $clog2(PULSE_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_PULSE,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CHAIN_W-1:0]  chain_q, chain_d;
    logic [CHAIN_W-1:0]  pix_cfg_q, pix_cfg_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [PCNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic                push_q;
    logic                pix_wr_q, pix_wr_d;
    logic                busy_q, busy_d;
    logic                full_q, full_d;
    logic                err_q, err_d;

    logic                push_edge_c;
    logic                idle_c;
    logic                shift_c;
    logic                pulse_last_c;

    assign push_edge_c  = bus.push_clk & ~push_q;
    assign idle_c       = (state_q == ST_IDLE);
    assign shift_c      = bus.config_en & idle_c;
    assign pulse_last_c = (pulse_cnt_q == PCNT_W'(PULSE_LEN - 1));

    // Next-state and datapath updates; shifting is only allowed while idle.
    always_comb begin
        state_d     = state_q;
        chain_d     = chain_q;
        pix_cfg_d   = pix_cfg_q;
        word_cnt_d  = word_cnt_q;
        pulse_cnt_d = '0;
        err_d       = err_q;

        unique case (state_q)
            ST_IDLE:  if (push_edge_c) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_PULSE;
            ST_PULSE: begin
                if (pulse_last_c) begin
                    state_d = ST_DONE;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PCNT_W'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (shift_c) begin
            // Truncating cast drops the oldest word off the top of the chain.
            chain_d = CHAIN_W'({chain_q, bus.config_data});
            if (word_cnt_q != CNT_W'(NUM_DCOL)) begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
            end
        end

        if (state_q == ST_LATCH) begin
            pix_cfg_d  = chain_q;
            word_cnt_d = '0;
        end

        if ((bus.config_en | push_edge_c) & ~idle_c) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end

        pix_wr_d = (state_d == ST_PULSE);
        busy_d   = (state_d != ST_IDLE);
        full_d   = (word_cnt_d == CNT_W'(NUM_DCOL));
    end

    // Push detector resets high so a request held across reset is not taken.
    always_ff @(posedge spi_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            chain_q     <= '0;
            pix_cfg_q   <= '0;
            word_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            push_q      <= 1'b1;
            pix_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            chain_q     <= chain_d;
            pix_cfg_q   <= pix_cfg_d;
            word_cnt_q  <= word_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            push_q      <= bus.push_clk;
            pix_wr_q    <= pix_wr_d;
            busy_q      <= busy_d;
            full_q      <= full_d;
            err_q       <= err_d;
        end
    end

    assign bus.config_do = chain_q[CHAIN_W-1];
    assign bus.pix_cfg   = pix_cfg_q;
    assign bus.pix_wr    = pix_wr_q;
    assign bus.cfg_busy  = busy_q;
    assign bus.cfg_full  = full_q;
    assign bus.word_cnt  = word_cnt_q;
    assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_pixel_config.sv
// Bench for pixel_config: load table, push/strobe timing, saturation,
// busy-time errors and reset abort, with a pix_cfg scoreboard.
module tb_pixel_config;
    localparam int unsigned NUM_DCOL  = 8;
    localparam int unsigned PULSE_LEN = 4;
    localparam int unsigned CHAIN_W   = NUM_DCOL * 6;

    logic clk;
    logic rst;

    pixel_config_if #(.NUM_DCOL(NUM_DCOL)) bus ();

    pixel_config #(.NUM_DCOL(NUM_DCOL), .PULSE_LEN(PULSE_LEN)) dut (
        .spi_clk (clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0]         hist[$];
    logic [CHAIN_W-1:0] exp_q[$];

    bit mon_en = 1'b0;
    bit abort  = 1'b0;

    typedef struct {
        logic [5:0] data;
        logic [3:0] exp_cnt;
        logic       exp_full;
        logic       exp_do;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected chain contents rebuilt from the list of words loaded.
    function automatic logic [CHAIN_W-1:0] model_chain();
        logic [CHAIN_W-1:0] r;
        r = '0;
        for (int i = 0; i < hist.size(); i++) r[6*i +: 6] = hist[hist.size()-1-i];
        return r;
    endfunction

    function automatic void model_load(input logic [5:0] w);
        hist.push_back(w);
        if (hist.size() > NUM_DCOL) void'(hist.pop_front());
    endfunction

    task automatic load(input logic [5:0] w);
        bus.config_en   = 1'b1;
        bus.config_data = w;
        model_load(w);
        tick();
        bus.config_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.cfg_busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check({name, " idle timeout"}, 64'(n < 20), 64'(1));
    endtask

    // Scoreboard and strobe/busy width monitor.
    bit wr_prev = 0, busy_prev = 0;
    int wr_len = 0, busy_len = 0;
    always @(negedge clk) begin
        if (mon_en && !abort) begin
            if (bus.pix_wr === 1'b1) begin
                if (!wr_prev) begin
                    if (exp_q.size() == 0) check("unexpected pix_wr", 64'(1), 64'(0));
                    else check("sb pix_cfg", 64'(bus.pix_cfg), 64'(exp_q.pop_front()));
                end
                wr_len++;
            end else if (wr_prev) begin
                check("pix_wr width", 64'(wr_len), 64'(PULSE_LEN));
                wr_len = 0;
            end
            if (bus.cfg_busy === 1'b1) busy_len++;
            else if (busy_prev) begin
                check("busy width", 64'(busy_len), 64'(PULSE_LEN + 2));
                busy_len = 0;
            end
            wr_prev   = (bus.pix_wr === 1'b1);
            busy_prev = (bus.cfg_busy === 1'b1);
        end else begin
            wr_prev = 0; wr_len = 0; busy_prev = 0; busy_len = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] wr_pat [7];
        for (int i = 0; i < 8; i++)
            vecs[i] = '{6'(i + 1), 4'(i + 1), (i == 7), 1'b0};
        vecs[8] = '{6'h3F, 4'd1, 1'b0, 1'b0};
        for (int j = 2; j <= 9; j++)
            vecs[7 + j] = '{6'h00, 4'(j > 8 ? 8 : j), (j >= 8), (j == 8)};
        // {pix_wr, cfg_busy} at the 7 samples following a push edge.
        wr_pat = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00};

        rst = 1'b1;
        bus.config_en = 1'b0; bus.config_data = '0;
        bus.push_clk = 1'b0;  bus.err_clr = 1'b0;
        tick(); tick();
        check("rst pix_cfg",  64'(bus.pix_cfg),  64'(0));
        check("rst pix_wr",   64'(bus.pix_wr),   64'(0));
        check("rst word_cnt", 64'(bus.word_cnt), 64'(0));
        check("rst busy",     64'(bus.cfg_busy), 64'(0));
        check("rst err",      64'(bus.cfg_err),  64'(0));
        check("rst do",       64'(bus.config_do), 64'(0));
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Eight loads 0x01..0x08.
        for (int i = 0; i < 8; i++) begin
            load(vecs[i].data);
            check($sformatf("load%0d cnt", i),  64'(bus.word_cnt),  64'(vecs[i].exp_cnt));
            check($sformatf("load%0d full", i), 64'(bus.cfg_full),  64'(vecs[i].exp_full));
            check($sformatf("load%0d do", i),   64'(bus.config_do), 64'(vecs[i].exp_do));
        end

        // Push with explicit cycle-by-cycle strobe timing.
        bus.push_clk = 1'b1;
        exp_q.push_back(model_chain());
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("push c%0d wr", k),   64'(bus.pix_wr),   64'(wr_pat[k][1]));
            check($sformatf("push c%0d busy", k), 64'(bus.cfg_busy), 64'(wr_pat[k][0]));
            if (k == 1) begin
                bus.push_clk = 1'b0;
                check("push top word", 64'(bus.pix_cfg[47:42]), 64'(6'h01));
                check("push low word", 64'(bus.pix_cfg[5:0]),  64'(6'h08));
                check("push word_cnt", 64'(bus.word_cnt),      64'(0));
            end
        end
        check("push full", 64'(bus.cfg_full), 64'(0));

        // Saturation past full: 0x3F followed by eight zeros.
        for (int i = 8; i < 17; i++) begin
            load(vecs[i].data);
            check($sformatf("load%0d cnt", i),  64'(bus.word_cnt),  64'(vecs[i].exp_cnt));
            check($sformatf("load%0d full", i), 64'(bus.cfg_full),  64'(vecs[i].exp_full));
            check($sformatf("load%0d do", i),   64'(bus.config_do), 64'(vecs[i].exp_do));
        end

        // Seven words then the eighth in the same cycle as the push edge.
        for (int i = 1; i <= 7; i++) load(6'(i));
        bus.config_en = 1'b1; bus.config_data = 6'h2A; bus.push_clk = 1'b1;
        model_load(6'h2A);
        exp_q.push_back(model_chain());
        tick();
        bus.config_en = 1'b0;
        tick();
        bus.push_clk = 1'b0;
        check("combo low word", 64'(bus.pix_cfg[5:0]), 64'(6'h2A));
        check("combo err", 64'(bus.cfg_err), 64'(0));
        wait_idle("combo");
        tick();

        // Load and second push while busy are ignored and flagged.
        bus.push_clk = 1'b1;
        exp_q.push_back(model_chain());
        tick(); tick();
        bus.push_clk = 1'b0;
        tick();
        bus.config_en = 1'b1; bus.config_data = 6'h15;
        tick();
        bus.config_en = 1'b0;
        check("busy load err", 64'(bus.cfg_err),   64'(1));
        check("busy load cnt", 64'(bus.word_cnt),  64'(0));
        check("busy load do",  64'(bus.config_do), 64'(model_chain()[CHAIN_W-1]));
        bus.push_clk = 1'b1;
        tick(); tick();
        bus.push_clk = 1'b0;
        wait_idle("busy push");
        tick(); tick();
        check("err sticky", 64'(bus.cfg_err), 64'(1));
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("err clr", 64'(bus.cfg_err), 64'(0));
        tick();

        // Reset during PULSE with push held across release.
        bus.push_clk = 1'b1;
        exp_q.push_back(model_chain());
        tick(); tick();
        bus.push_clk = 1'b0;
        bus.config_en = 1'b1; bus.config_data = 6'h11; bus.err_clr = 1'b1;
        tick();
        bus.config_en = 1'b0; bus.err_clr = 1'b0;
        check("set beats clr", 64'(bus.cfg_err), 64'(1));
        check("mid pulse wr",  64'(bus.pix_wr),  64'(1));
        abort = 1'b1;
        rst = 1'b1;
        bus.push_clk = 1'b1;
        hist.delete();
        tick();
        rst = 1'b0;
        check("abort pix_wr",  64'(bus.pix_wr),   64'(0));
        check("abort busy",    64'(bus.cfg_busy), 64'(0));
        check("abort pix_cfg", 64'(bus.pix_cfg),  64'(0));
        check("abort err",     64'(bus.cfg_err),  64'(0));
        check("abort cnt",     64'(bus.word_cnt), 64'(0));
        tick();
        abort = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("held push c%0d busy", k), 64'(bus.cfg_busy), 64'(0));
        end
        bus.push_clk = 1'b0;
        tick(); tick();
        check("scoreboard empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
